// File: rtl/fpu_pkg.sv
// Shared FPU wrapper types: fsqrt pipe latency, fp32 operand type and writeback tag type.
package fpu_pkg;
  localparam int FSQRT_LATENCY = 3;
  localparam int FPU_TAG_W     = 6;

  typedef logic [31:0]          fp32_t;
  typedef logic [FPU_TAG_W-1:0] fpu_tag_t;
endpackage

// File: rtl/fpu_result_fifo.sv
// First-word-fall-through result FIFO with occupancy count and synchronous clear; 1-cycle write-to-head.
// Push and pop may coincide at any occupancy; a pop on empty is ignored; the producer must never overfill it.
module fpu_result_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 38
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clr,
  input  logic                       push,
  input  logic [W-1:0]               push_dat,
  input  logic                       pop,
  output logic                       vld,
  output logic [W-1:0]               dat,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          pop_eff;

  assign pop_eff = pop && (count_q != '0);
  assign vld     = (count_q != '0);
  // Head reads as zero when empty so the writeback bus is quiet.
  assign dat     = vld ? mem_q[rd_ptr_q] : '0;
  assign count   = count_q;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = push_dat;
        wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (pop_eff) rd_ptr_d = rd_ptr_q + AW'(1);
      if (push && !pop_eff)      count_d = count_q + CW'(1);
      else if (!push && pop_eff) count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always @(posedge clk) begin
    if (rst_n && !clr) assert (!(push && !pop_eff && count_q == CW'(DEPTH)));
  end
endmodule

// File: rtl/fsqrt_issue_buf.sv
// Credit-gated issue wrapper around the fixed-latency fsqrt pipe; accept-to-wb_valid is LATENCY+1 cycles.
// Dispatch sees valid/ready backed by DEPTH credits; writeback backpressure is absorbed by the result FIFO.
module fsqrt_issue_buf
  import fpu_pkg::*;
#(
  parameter int LATENCY = FSQRT_LATENCY,
  parameter int DEPTH   = 4,
  parameter int TAG_W   = FPU_TAG_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             req_valid,
  output logic             req_ready,
  input  fp32_t            req_data,
  input  logic [TAG_W-1:0] req_tag,
  output fp32_t            sq_a,
  output logic             sq_valid,
  input  fp32_t            sq_result,
  input  logic             sq_out_valid,
  output logic             wb_valid,
  input  logic             wb_ready,
  output fp32_t            wb_data,
  output logic [TAG_W-1:0] wb_tag,
  output logic             busy,
  output logic             err_sticky
);
  localparam int CW = $clog2(DEPTH+1);

  logic             shadow_vld_q [LATENCY];
  logic             shadow_vld_d [LATENCY];
  logic [TAG_W-1:0] shadow_tag_q [LATENCY];
  logic [TAG_W-1:0] shadow_tag_d [LATENCY];
  logic [CW-1:0]    inflight_q, inflight_d;
  logic             err_q, err_d;

  logic [CW-1:0]    fifo_count;
  logic [CW:0]      credits_used;
  logic             accept, retire;
  logic [TAG_W+31:0] fifo_dat;

  // Credits come from registered state only, so a pop frees its slot one cycle later.
  assign credits_used = {1'b0, fifo_count} + {1'b0, inflight_q};
  assign req_ready    = !flush && (credits_used < (CW+1)'(DEPTH));
  assign accept       = req_valid && req_ready;
  assign retire       = shadow_vld_q[LATENCY-1] && sq_out_valid;

  assign sq_a       = req_data;
  assign sq_valid   = accept;
  assign busy       = (inflight_q != '0) || (fifo_count != '0);
  assign err_sticky = err_q;
  assign wb_tag     = fifo_dat[TAG_W+31:32];
  assign wb_data    = fifo_dat[31:0];

  always_comb begin
    shadow_vld_d[0] = accept;
    shadow_tag_d[0] = req_tag;
    for (int i = 1; i < LATENCY; i++) begin
      shadow_vld_d[i] = shadow_vld_q[i-1];
      shadow_tag_d[i] = shadow_tag_q[i-1];
    end
    inflight_d = inflight_q;
    if (accept && !retire)      inflight_d = inflight_q + CW'(1);
    else if (!accept && retire) inflight_d = inflight_q - CW'(1);
    // The pipe keeps running through a flush, so the mismatch check stays live.
    err_d = err_q || (shadow_vld_q[LATENCY-1] && !sq_out_valid);
    if (flush) begin
      for (int i = 0; i < LATENCY; i++) shadow_vld_d[i] = 1'b0;
      inflight_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LATENCY; i++) begin
        shadow_vld_q[i] <= 1'b0;
        shadow_tag_q[i] <= '0;
      end
      inflight_q <= '0;
      err_q      <= 1'b0;
    end else begin
      shadow_vld_q <= shadow_vld_d;
      shadow_tag_q <= shadow_tag_d;
      inflight_q   <= inflight_d;
      err_q        <= err_d;
    end
  end

  fpu_result_fifo #(
    .DEPTH (DEPTH),
    .W     (TAG_W + 32)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (flush),
    .push     (retire && !flush),
    .push_dat ({shadow_tag_q[LATENCY-1], sq_result}),
    .pop      (wb_ready && !flush),
    .vld      (wb_valid),
    .dat      (fifo_dat),
    .count    (fifo_count)
  );
endmodule
